// File: rtl/column_pattern_seq.sv
// column_pattern_seq
//
// Double-buffered column pattern sequencer. Commands arriving on the SPI
// command strobe fill a back bank of 28-bit column patterns; a trigger
// generator steps through the front bank one column at a time. A SWAP request
// is latched and only takes effect at the next frame boundary, so the
// displayed frame never tears. The frame length is shadowed the same way.
//
// Ports
//   clk            system clock
//   i_RESET_n      synchronous active-low reset
//   i_wr_valid     one-cycle strobe qualifying i_wr_data
//   i_wr_data      command word: [31:28] opcode, [27:0] payload
//   i_step         one-cycle column-advance strobe
//   i_head         one-cycle frame-restart strobe
//   o_pattern      current column pattern (0 when idle or blanked), registered
//   o_col_idx      current column index, registered
//   o_frame_start  one-cycle pulse after each frame boundary
//   o_swap_pending bank swap requested but not yet applied
//   o_err          sticky error flag (bad SET_LEN or reserved opcode)
//
// Opcodes: 0 NOP, 1 SET_ADDR, 2 WRITE, 3 SET_LEN, 4 SWAP, 5 BLANK, 6 CLR_ERR,
// 7..F reserved (flag an error).

module column_pattern_seq #(
    parameter int COLS = 32,
    localparam int AW = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          i_RESET_n,
    input  logic          i_wr_valid,
    input  logic [31:0]   i_wr_data,
    input  logic          i_step,
    input  logic          i_head,
    output logic [27:0]   o_pattern,
    output logic [AW-1:0] o_col_idx,
    output logic          o_frame_start,
    output logic          o_swap_pending,
    output logic          o_err
);

    // Length needs one more bit than the index so that len == COLS fits.
    localparam int LW = AW + 1;
    localparam logic [6:0]    COLS7   = 7'(COLS);
    localparam logic [LW-1:0] COLS_LW = LW'(COLS);

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_SET_ADDR = 4'h1;
    localparam logic [3:0] OP_WRITE    = 4'h2;
    localparam logic [3:0] OP_SET_LEN  = 4'h3;
    localparam logic [3:0] OP_SWAP     = 4'h4;
    localparam logic [3:0] OP_BLANK    = 4'h5;
    localparam logic [3:0] OP_CLR_ERR  = 4'h6;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e state_q, state_d;

    // Pattern storage; deliberately not reset.
    logic [27:0] bank0_mem [COLS];
    logic [27:0] bank1_mem [COLS];

    // front_sel = 0 -> bank0 is displayed, bank1 receives writes.
    logic          front_sel_q, front_sel_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] len_shadow_q, len_shadow_d;
    logic          blank_q, blank_d;
    logic          swap_pending_q, swap_pending_d;
    logic          err_q, err_d;
    logic [AW-1:0] col_q, col_d;
    logic          frame_start_q, frame_start_d;
    logic [27:0]   pattern_q, pattern_d;

    logic [3:0]  opcode;
    logic [27:0] payload;
    logic [6:0]  len_val;
    logic        len_legal;
    logic        cmd_write;
    logic        cmd_swap;
    logic        last_col;
    logic        boundary;
    logic [27:0] front_rd;

    assign opcode    = i_wr_data[31:28];
    assign payload   = i_wr_data[27:0];
    assign len_val   = payload[6:0];
    assign len_legal = (len_val != 7'd0) && (len_val <= COLS7);

    assign last_col = ({1'b0, col_q} == (len_q - 1'b1));
    // i_head always forces a boundary; a simultaneous i_step is absorbed.
    assign boundary = i_head || ((state_q == StRun) && i_step && last_col);

    // Command decode.
    always_comb begin
        wptr_d       = wptr_q;
        len_shadow_d = len_shadow_q;
        blank_d      = blank_q;
        err_d        = err_q;
        cmd_write    = 1'b0;
        cmd_swap     = 1'b0;
        if (i_wr_valid) begin
            case (opcode)
                OP_NOP: ;
                OP_SET_ADDR: wptr_d = payload[AW-1:0];
                OP_WRITE: begin
                    cmd_write = 1'b1;
                    wptr_d    = wptr_q + 1'b1;  // power-of-2 depth wraps naturally
                end
                OP_SET_LEN: begin
                    if (len_legal) begin
                        len_shadow_d = len_val[LW-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_SWAP:    cmd_swap = 1'b1;
                OP_BLANK:   blank_d  = payload[0];
                OP_CLR_ERR: err_d    = 1'b0;
                default:    err_d    = 1'b1;
            endcase
        end
    end

    // Sequencer state machine and frame bookkeeping.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        len_d          = len_q;
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q;
        frame_start_d  = 1'b0;

        case (state_q)
            StIdle:  if (i_head) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase

        if (boundary) begin
            col_d         = '0;
            frame_start_d = 1'b1;
            len_d         = len_shadow_q;
            // Only a swap already pending before this cycle is applied here.
            if (swap_pending_q) begin
                front_sel_d    = ~front_sel_q;
                swap_pending_d = 1'b0;
            end
        end else if ((state_q == StRun) && i_step) begin
            col_d = col_q + 1'b1;
        end

        // A SWAP arriving on a boundary cycle waits for the next boundary.
        if (cmd_swap) begin
            swap_pending_d = 1'b1;
        end
    end

    // Read the next front column so pattern and index register together.
    always_comb begin
        front_rd  = front_sel_d ? bank1_mem[col_d] : bank0_mem[col_d];
        pattern_d = ((state_d == StRun) && !blank_d) ? front_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (i_RESET_n && cmd_write) begin
            if (front_sel_q) begin
                bank0_mem[wptr_q] <= payload;
            end else begin
                bank1_mem[wptr_q] <= payload;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_RESET_n) begin
            state_q        <= StIdle;
            front_sel_q    <= 1'b0;
            wptr_q         <= '0;
            len_q          <= COLS_LW;
            len_shadow_q   <= COLS_LW;
            blank_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            err_q          <= 1'b0;
            col_q          <= '0;
            frame_start_q  <= 1'b0;
            pattern_q      <= '0;
        end else begin
            state_q        <= state_d;
            front_sel_q    <= front_sel_d;
            wptr_q         <= wptr_d;
            len_q          <= len_d;
            len_shadow_q   <= len_shadow_d;
            blank_q        <= blank_d;
            swap_pending_q <= swap_pending_d;
            err_q          <= err_d;
            col_q          <= col_d;
            frame_start_q  <= frame_start_d;
            pattern_q      <= pattern_d;
        end
    end

    assign o_pattern      = pattern_q;
    assign o_col_idx      = col_q;
    assign o_frame_start  = frame_start_q;
    assign o_swap_pending = swap_pending_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_column_pattern_seq.sv
// tb_column_pattern_seq
//
// Directed bench for column_pattern_seq with COLS = 32. Inputs change 1 time
// unit after the rising edge and outputs are checked there too, after the
// registered outputs have settled.

module tb_column_pattern_seq;

    localparam int COLS = 32;
    localparam int AW   = 5;

    logic          clk = 1'b0;
    logic          i_RESET_n;
    logic          i_wr_valid;
    logic [31:0]   i_wr_data;
    logic          i_step;
    logic          i_head;
    logic [27:0]   o_pattern;
    logic [AW-1:0] o_col_idx;
    logic          o_frame_start;
    logic          o_swap_pending;
    logic          o_err;

    int n_total = 0;
    int n_pass  = 0;

    column_pattern_seq #(.COLS(COLS)) dut (
        .clk            (clk),
        .i_RESET_n      (i_RESET_n),
        .i_wr_valid     (i_wr_valid),
        .i_wr_data      (i_wr_data),
        .i_step         (i_step),
        .i_head         (i_head),
        .o_pattern      (o_pattern),
        .o_col_idx      (o_col_idx),
        .o_frame_start  (o_frame_start),
        .o_swap_pending (o_swap_pending),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          head;
        logic          step;
        logic [AW-1:0] col;
        logic [27:0]   pat;
        logic          fs;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input logic [AW-1:0] col,
                             input logic [27:0] pat, input logic fs);
        check($sformatf("%s col", tag), 32'(o_col_idx), 32'(col));
        check($sformatf("%s pattern", tag), 32'(o_pattern), 32'(pat));
        check($sformatf("%s frame_start", tag), 32'(o_frame_start), 32'(fs));
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [27:0] pl,
                         input logic h, input logic s);
        i_wr_valid = v;
        i_wr_data  = {op, pl};
        i_head     = h;
        i_step     = s;
        @(posedge clk);
        #1;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        i_head     = 1'b0;
        i_step     = 1'b0;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [27:0] pl);
        drive(1'b1, op, pl, 1'b0, 1'b0);
    endtask

    task automatic step();
        drive(1'b0, 4'h0, 28'h0, 1'b0, 1'b1);
    endtask

    task automatic head();
        drive(1'b0, 4'h0, 28'h0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 28'h0, 1'b0, 1'b0);
    endtask

    // Reset with every strobe asserted so that anything leaking through shows up.
    task automatic do_reset(input int n);
        i_RESET_n  = 1'b0;
        i_wr_valid = 1'b1;
        i_wr_data  = {4'h4, 28'h0};
        i_head     = 1'b1;
        i_step     = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        i_RESET_n  = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        i_head     = 1'b0;
        i_step     = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_out(tag, '0, 28'h0, 1'b0);
        check($sformatf("%s swap_pending", tag), 32'(o_swap_pending), 32'd0);
        check($sformatf("%s err", tag), 32'(o_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_RESET_n  = 1'b0;
        i_wr_valid = 1'b0;
        i_wr_data  = '0;
        i_step     = 1'b0;
        i_head     = 1'b0;

        // Four-column frame after SET_LEN 4: steps walk 1,2,3 then wrap.
        tbl[0] = '{head: 1'b0, step: 1'b1, col: 5'd1, pat: 28'h2, fs: 1'b0};
        tbl[1] = '{head: 1'b0, step: 1'b1, col: 5'd2, pat: 28'h3, fs: 1'b0};
        tbl[2] = '{head: 1'b0, step: 1'b1, col: 5'd3, pat: 28'h4, fs: 1'b0};
        tbl[3] = '{head: 1'b0, step: 1'b1, col: 5'd0, pat: 28'h1, fs: 1'b1};
        tbl[4] = '{head: 1'b0, step: 1'b0, col: 5'd0, pat: 28'h1, fs: 1'b0};

        do_reset(3);
        check_reset_state("reset");

        step();
        check_out("idle step", 5'd0, 28'h0, 1'b0);

        // Load back bank (bank1) with 1..4 and swap it in.
        cmd(4'h1, 28'h0);
        for (int i = 1; i <= 4; i++) cmd(4'h2, 28'(i));
        cmd(4'h4, 28'h0);
        check("swap pending set", 32'(o_swap_pending), 32'd1);
        head();
        check_out("first head", 5'd0, 28'h1, 1'b1);
        check("swap pending cleared", 32'(o_swap_pending), 32'd0);
        idle();
        check("frame_start one cycle", 32'(o_frame_start), 32'd0);

        cmd(4'h3, 28'd4);
        check("set_len 4 err", 32'(o_err), 32'd0);
        head();
        check_out("len4 head", 5'd0, 28'h1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'h0, 28'h0, tbl[i].head, tbl[i].step);
            check_out($sformatf("tbl[%0d]", i), tbl[i].col, tbl[i].pat, tbl[i].fs);
        end

        // Error handling.
        cmd(4'h3, 28'd0);
        check("set_len 0 err", 32'(o_err), 32'd1);
        cmd(4'h6, 28'h0);
        check("clr_err", 32'(o_err), 32'd0);
        cmd(4'h3, 28'(COLS + 1));
        check("set_len cols+1 err", 32'(o_err), 32'd1);
        cmd(4'h9, 28'h0);
        check("op9 err stays", 32'(o_err), 32'd1);
        cmd(4'h6, 28'h0);
        check("clr_err 2", 32'(o_err), 32'd0);
        cmd(4'h9, 28'h0);
        check("op9 sets err", 32'(o_err), 32'd1);
        cmd(4'h6, 28'h0);
        check("clr_err 3", 32'(o_err), 32'd0);
        // Rejected lengths left the frame at 4 columns.
        step(); step(); step();
        check_out("len kept col3", 5'd3, 28'h4, 1'b0);
        step();
        check_out("len kept wrap", 5'd0, 28'h1, 1'b1);

        // Mid-frame writes to the back bank (bank0) must not disturb output.
        step();
        cmd(4'h1, 28'h0);
        cmd(4'h2, 28'h0000011);
        cmd(4'h2, 28'hABCDEF0);
        cmd(4'h2, 28'h0000033);
        cmd(4'h2, 28'h0000044);
        check_out("after writes", 5'd1, 28'h2, 1'b0);
        step(); step(); step();
        check_out("no swap wrap", 5'd0, 28'h1, 1'b1);
        cmd(4'h4, 28'h0);
        step();
        check_out("swap pending mid", 5'd1, 28'h2, 1'b0);
        step(); step(); step();
        check_out("swap applied", 5'd0, 28'h0000011, 1'b1);
        check("swap pending after", 32'(o_swap_pending), 32'd0);
        step();
        check_out("new col1", 5'd1, 28'hABCDEF0, 1'b0);

        // Head and step together: single boundary.
        step();
        check_out("at col2", 5'd2, 28'h0000033, 1'b0);
        drive(1'b0, 4'h0, 28'h0, 1'b1, 1'b1);
        check_out("head+step", 5'd0, 28'h0000011, 1'b1);
        idle();
        check_out("head+step after", 5'd0, 28'h0000011, 1'b0);

        // SWAP on a boundary cycle is deferred to the next boundary.
        drive(1'b1, 4'h4, 28'h0, 1'b1, 1'b0);
        check_out("swap at boundary", 5'd0, 28'h0000011, 1'b1);
        check("deferred pending", 32'(o_swap_pending), 32'd1);
        step();
        check_out("deferred col1", 5'd1, 28'hABCDEF0, 1'b0);
        head();
        check_out("deferred applied", 5'd0, 28'h1, 1'b1);
        check("deferred cleared", 32'(o_swap_pending), 32'd0);

        // Length change mid-frame waits for the boundary.
        step();
        cmd(4'h3, 28'd2);
        step();
        check_out("shadow len col2", 5'd2, 28'h3, 1'b0);
        step(); step();
        check_out("shadow len wrap4", 5'd0, 28'h1, 1'b1);
        step(); step();
        check_out("len2 wrap", 5'd0, 28'h1, 1'b1);

        // Blanking keeps the index moving.
        cmd(4'h5, 28'h1);
        check_out("blank on", 5'd0, 28'h0, 1'b0);
        step();
        check_out("blank col1", 5'd1, 28'h0, 1'b0);
        step();
        check_out("blank wrap", 5'd0, 28'h0, 1'b1);
        step();
        cmd(4'h5, 28'h0);
        check_out("blank off", 5'd1, 28'h2, 1'b0);

        // Reset mid-frame with a pending swap and an error flagged.
        cmd(4'h4, 28'h0);
        cmd(4'hF, 28'h0);
        check("pre-reset err", 32'(o_err), 32'd1);
        do_reset(2);
        check_reset_state("mid reset");
        step();
        check_out("post reset idle", 5'd0, 28'h0, 1'b0);
        head();
        check_out("post reset head", 5'd0, 28'h0000011, 1'b1);
        step();
        check_out("post reset len", 5'd1, 28'hABCDEF0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
